// File: rtl/rb_pkg.sv
// Shared definitions for the digitizer ring buffer write and readout address controllers.
package rb_pkg;

  localparam int unsigned RB_SIZE = 10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_POST    = 3'd2;
  localparam logic [2:0] ST_SETTLE  = 3'd3;
  localparam logic [2:0] ST_READOUT = 3'd4;

  typedef enum logic [2:0] {
    StIdle    = ST_IDLE,
    StArmed   = ST_ARMED,
    StPost    = ST_POST,
    StSettle  = ST_SETTLE,
    StReadout = ST_READOUT
  } rb_state_e;

endpackage

// File: rtl/rb_write_cntrl.sv
// Ring buffer write-side controller: wrapping write pointer, trigger capture,
// post-trigger countdown and readout request handshake.
module rb_write_cntrl
  import rb_pkg::*;
#(
  parameter int unsigned SIZE = RB_SIZE
) (
  input  logic            sysclk,
  input  logic            rst,
  input  logic            arm,
  input  logic            abort,
  input  logic            sample_valid,
  input  logic            trigger,
  input  logic [SIZE-1:0] posttrig_in,
  input  logic            ro_done_n,
  output logic            wr_en,
  output logic [SIZE-1:0] wr_addr,
  output logic [SIZE-1:0] ain_out,
  output logic            rd_request,
  output logic            filled,
  output logic [2:0]      state
);

  rb_state_e       state_q, state_d;
  logic [SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [SIZE-1:0] postcnt_q, postcnt_d;
  logic            filled_q, filled_d;
  logic            rd_request_q;

  assign wr_en      = sample_valid & ((state_q == StArmed) | (state_q == StPost));
  assign wr_addr    = wr_addr_q;
  assign ain_out    = wr_addr_q;
  assign rd_request = rd_request_q;
  assign filled     = filled_q;
  assign state      = state_q;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    postcnt_d = postcnt_q;
    filled_d  = filled_q;

    if (wr_en) begin
      wr_addr_d = wr_addr_q + SIZE'(1);
      if (wr_addr_q == '1) begin
        filled_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d  = StArmed;
          filled_d = 1'b0;
        end
      end
      StArmed: begin
        // The trigger-cycle write is the trigger sample itself, not a post sample.
        if (trigger) begin
          postcnt_d = posttrig_in;
          state_d   = (posttrig_in != '0) ? StPost : StSettle;
        end
      end
      StPost: begin
        if (wr_en) begin
          postcnt_d = postcnt_q - SIZE'(1);
          if (postcnt_q == SIZE'(1)) begin
            state_d = StSettle;
          end
        end
      end
      // One quiet cycle so the reader latches ain_out while rd_request is low.
      StSettle:  state_d = StReadout;
      StReadout: begin
        if (!ro_done_n) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d   = StIdle;
      postcnt_d = '0;
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_addr_q    <= '0;
      postcnt_q    <= '0;
      filled_q     <= 1'b0;
      rd_request_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      postcnt_q    <= postcnt_d;
      filled_q     <= filled_d;
      rd_request_q <= (state_d == StReadout);
    end
  end

endmodule
